ysyx_23060111_dmem_resp: RTL and testbench

Data-memory responder on the far end of the core's load/store port (m_ren/m_raddr/m_rmask, m_wen/m_waddr/m_wdata/m_wmask).
- Accepts one load or store request at a time and holds it through a programmable wait-state latency.
- Performs byte-lane alignment against an internal word array and returns right-aligned read data; the core sign- or zero-extends from bit 0.
- Sits between the execute stage and on-chip RAM. It replaces the DPI memory model for synthesis.

---
 rtl/ysyx_23060111_mem_pkg.sv | 31 +++
 rtl/ysyx_23060111_dmem_sram.sv | 28 ++
 rtl/ysyx_23060111_dmem_resp.sv | 132 +++++++++++++
 tb/tb_ysyx_23060111_dmem_resp.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060111_mem_pkg.sv
// Shared state encoding, access-size codes and byte-lane helper for the
// ysyx_23060111 data-memory responder.
package ysyx_23060111_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  localparam logic [31:0] SZ_B = 32'd1;
  localparam logic [31:0] SZ_H = 32'd2;
  localparam logic [31:0] SZ_W = 32'd4;

  localparam logic [31:0] DMEM_ADDR_BASE = 32'h8000_0000;

  // Halfword lanes pair up on addr[1]; misaligned halves are rejected upstream.
  function automatic logic [3:0] size_to_be(input logic [31:0] size,
                                            input logic [1:0]  off);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = 4'b0011 << {off[1], 1'b0};
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ysyx_23060111_dmem_sram.sv
// Single-port DEPTH_WORDS x 32 word array: registered read every cycle,
// byte-enable write on the same address.
module ysyx_23060111_dmem_sram
  import ysyx_23060111_mem_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 4096,
  localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] addr,
  input  logic             wen,
  input  logic [3:0]       be,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wen && be[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ysyx_23060111_dmem_resp.sv
// Data-memory responder: accepts one load/store, holds it for LATENCY cycles,
// then commits the write or returns right-aligned read data.
module ysyx_23060111_dmem_resp
  import ysyx_23060111_mem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = DMEM_ADDR_BASE,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m_ren,
  input  logic [31:0] m_raddr,
  input  logic [31:0] m_rmask,
  input  logic        m_wen,
  input  logic [31:0] m_waddr,
  input  logic [31:0] m_wdata,
  input  logic [31:0] m_wmask,
  output logic        m_busy,
  output logic        m_rvalid,
  output logic [31:0] m_rdata,
  output logic        m_wdone,
  output logic        m_err
);

  localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
  localparam logic [32:0] ADDR_END = {1'b0, ADDR_BASE} + 33'(DEPTH_WORDS) * 33'd4;

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - ADDR_BASE) >> 2);
  endfunction

  mem_state_e  state_q;
  logic [3:0]  cnt_q;
  logic        op_wr_q;
  logic [31:0] addr_q;
  logic [31:0] size_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_hold_q;

  logic        accept;
  logic        misaligned;
  logic        out_of_range;
  logic        bad_size;
  logic        req_err;
  logic [31:0] rd_shift;
  logic [31:0] rd_fmt;
  logic [31:0] sram_rdata;
  logic [31:0] in_addr;

  assign accept  = (state_q == IDLE) && (m_wen || m_ren);
  assign in_addr = m_wen ? m_waddr : m_raddr;

  assign misaligned   = ((size_q == SZ_H) && addr_q[0]) ||
                        ((size_q == SZ_W) && (addr_q[1:0] != 2'b00));
  assign out_of_range = (addr_q < ADDR_BASE) || ({1'b0, addr_q} >= ADDR_END);
  assign bad_size     = (size_q != SZ_B) && (size_q != SZ_H) && (size_q != SZ_W);
  assign req_err      = misaligned || out_of_range || bad_size;

  assign rd_shift = sram_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    rd_fmt = 32'h0;
    if (!req_err) begin
      case (size_q)
        SZ_B:    rd_fmt = {24'h0, rd_shift[7:0]};
        SZ_H:    rd_fmt = {16'h0, rd_shift[15:0]};
        SZ_W:    rd_fmt = rd_shift;
        default: rd_fmt = 32'h0;
      endcase
    end
  end

  // The array is read every cycle; in IDLE it looks at the incoming address so
  // that a LATENCY=1 access has its word ready in RESP.
  ysyx_23060111_dmem_sram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_sram (
    .clk  (clk),
    .addr ((state_q == IDLE) ? word_idx(in_addr) : word_idx(addr_q)),
    .wen  ((state_q == RESP) && op_wr_q && !req_err),
    .be   (size_to_be(size_q, addr_q[1:0])),
    .wdata(wdata_q << {addr_q[1:0], 3'b000}),
    .rdata(sram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      op_wr_q      <= 1'b0;
      addr_q       <= 32'h0;
      size_q       <= 32'h0;
      wdata_q      <= 32'h0;
      rdata_hold_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_wr_q <= m_wen;
            addr_q  <= in_addr;
            size_q  <= m_wen ? m_wmask : m_rmask;
            wdata_q <= m_wdata;
            cnt_q   <= CNT_INIT;
            state_q <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          if (!op_wr_q) begin
            rdata_hold_q <= rd_fmt;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_busy   = (state_q != IDLE);
  assign m_rvalid = (state_q == RESP) && !op_wr_q;
  assign m_wdone  = (state_q == RESP) && op_wr_q;
  assign m_err    = (state_q == RESP) && req_err;
  assign m_rdata  = m_rvalid ? rd_fmt : rdata_hold_q;

endmodule

// File: tb/tb_ysyx_23060111_dmem_resp.sv
// Scoreboard bench for ysyx_23060111_dmem_resp: directed loads/stores push
// expected responses, a negedge monitor pops and checks them.
module tb_ysyx_23060111_dmem_resp;

  localparam int unsigned LAT = 2;

  logic        clk;
  logic        rst_n;
  logic        m_ren;
  logic [31:0] m_raddr;
  logic [31:0] m_rmask;
  logic        m_wen;
  logic [31:0] m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] m_wmask;
  logic        m_busy;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        m_wdone;
  logic        m_err;

  typedef struct {
    bit          wr;
    bit          err;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  ysyx_23060111_dmem_resp #(
    .ADDR_BASE  (32'h8000_0000),
    .DEPTH_WORDS(4096),
    .LATENCY    (LAT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_ren   (m_ren),
    .m_raddr (m_raddr),
    .m_rmask (m_rmask),
    .m_wen   (m_wen),
    .m_waddr (m_waddr),
    .m_wdata (m_wdata),
    .m_wmask (m_wmask),
    .m_busy  (m_busy),
    .m_rvalid(m_rvalid),
    .m_rdata (m_rdata),
    .m_wdone (m_wdone),
    .m_err   (m_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every response pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && (m_rvalid || m_wdone)) begin
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_resp: got rvalid=%0b wdone=%0b, expected no pulse",
                 m_rvalid, m_wdone);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("resp_kind_wdone", 32'(m_wdone), 32'(e.wr));
        checkOutput("resp_kind_rvalid", 32'(m_rvalid), 32'(!e.wr));
        checkOutput("resp_err", 32'(m_err), 32'(e.err));
        checkOutput("resp_cycle", 32'(cyc), 32'(e.due));
        if (!e.wr) checkOutput("resp_rdata", m_rdata, e.rdata);
      end
    end
  end

  task automatic waitIdle();
    int n = 0;
    while (m_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (m_busy) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL idle_timeout: got busy=1, expected busy=0 within 100 cycles");
    end
  endtask

  // Drives one request at a negedge while idle; returns at the next negedge.
  task automatic applyStimulus(input bit do_wr, input bit do_rd,
                               input logic [31:0] addr, input logic [31:0] size,
                               input logic [31:0] data, input bit exp_err,
                               input logic [31:0] exp_rdata);
    exp_t e;
    waitIdle();
    m_wen   = do_wr;
    m_waddr = addr;
    m_wmask = do_wr ? size : 32'd0;
    m_wdata = data;
    m_ren   = do_rd;
    m_raddr = addr;
    m_rmask = do_rd ? size : 32'd0;
    e.wr    = do_wr;
    e.err   = exp_err;
    e.rdata = exp_rdata;
    e.due   = cyc + LAT;
    sb.push_back(e);
    @(negedge clk);
    m_wen = 1'b0;
    m_ren = 1'b0;
  endtask

  task automatic doWrite(input logic [31:0] addr, input logic [31:0] size,
                         input logic [31:0] data, input bit exp_err);
    applyStimulus(1'b1, 1'b0, addr, size, data, exp_err, 32'h0);
  endtask

  task automatic doRead(input logic [31:0] addr, input logic [31:0] size,
                        input logic [31:0] exp_rdata, input bit exp_err);
    applyStimulus(1'b0, 1'b1, addr, size, 32'h0, exp_err, exp_rdata);
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    m_ren   = 1'b0;
    m_raddr = 32'h0;
    m_rmask = 32'h0;
    m_wen   = 1'b0;
    m_waddr = 32'h0;
    m_wdata = 32'h0;
    m_wmask = 32'h0;
    #1;
    checkOutput("reset_flags", {28'h0, m_busy, m_rvalid, m_wdone, m_err}, 32'h0);
    checkOutput("reset_rdata", m_rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Word, byte and halfword stores with read-back
    doWrite(32'h8000_0010, 32'd4, 32'hDEAD_BEEF, 1'b0);
    doRead (32'h8000_0010, 32'd4, 32'hDEAD_BEEF, 1'b0);
    doWrite(32'h8000_0013, 32'd1, 32'hFFFF_FF5A, 1'b0);
    doRead (32'h8000_0010, 32'd4, 32'h5AAD_BEEF, 1'b0);
    doRead (32'h8000_0013, 32'd1, 32'h0000_005A, 1'b0);
    doWrite(32'h8000_0012, 32'd2, 32'hAAAA_1234, 1'b0);
    doRead (32'h8000_0012, 32'd2, 32'h0000_1234, 1'b0);
    doRead (32'h8000_0010, 32'd4, 32'h1234_BEEF, 1'b0);
    doRead (32'h8000_0011, 32'd2, 32'h0000_0000, 1'b1);
    doRead (32'h8000_0011, 32'd1, 32'h0000_00BE, 1'b0);
    doRead (32'h8000_0012, 32'd4, 32'h0000_0000, 1'b1);

    // Range edges: neither out-of-range store may alias onto word 0
    doWrite(32'h8000_0000, 32'd4, 32'hCAFE_F00D, 1'b0);
    doWrite(32'h7FFF_FFFC, 32'd4, 32'h0BAD_BAD0, 1'b1);
    doWrite(32'h8000_4000, 32'd4, 32'h0BAD_BAD1, 1'b1);
    doRead (32'h8000_0000, 32'd4, 32'hCAFE_F00D, 1'b0);
    doWrite(32'h8000_3FFC, 32'd4, 32'h7654_3210, 1'b0);
    doRead (32'h8000_3FFC, 32'd4, 32'h7654_3210, 1'b0);
    doRead (32'h8000_4000, 32'd4, 32'h0000_0000, 1'b1);

    // Illegal size on both directions
    doWrite(32'h8000_0000, 32'd3, 32'hFFFF_FFFF, 1'b1);
    doRead (32'h8000_0002, 32'd2, 32'h0000_CAFE, 1'b0);
    doRead (32'h8000_0014, 32'd3, 32'h0000_0000, 1'b1);

    // Simultaneous write and read: only the write is served
    applyStimulus(1'b1, 1'b1, 32'h8000_0020, 32'd4, 32'h1122_3344, 1'b0, 32'h0);
    checkOutput("busy_T+1", 32'(m_busy), 32'd1);
    for (int i = 2; i <= int'(LAT) + 1; i++) begin
      @(negedge clk);
      checkOutput("busy_window", 32'(m_busy), (i <= int'(LAT)) ? 32'd1 : 32'd0);
    end
    doRead(32'h8000_0020, 32'd4, 32'h1122_3344, 1'b0);

    // Reset one cycle after a store is accepted abandons it
    waitIdle();
    m_wen   = 1'b1;
    m_waddr = 32'h8000_0020;
    m_wmask = 32'd4;
    m_wdata = 32'h9999_9999;
    @(negedge clk);
    m_wen = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_flags", {28'h0, m_busy, m_rvalid, m_wdone, m_err}, 32'h0);
    checkOutput("midreset_rdata", m_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    doRead(32'h8000_0020, 32'd4, 32'h1122_3344, 1'b0);

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("sb_drain", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
